// File: rtl/filter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : filter_ctrl_pkg
//  Description : Shared constants, types and helpers for the filter_ctrl block
//  Revision    : 1.0  initial release
// ============================================================================
package filter_ctrl_pkg;

    // Switch indices that select the target group of the four keys
    localparam int unsigned T0_SW = 1;
    localparam int unsigned T1_SW = 2;
    localparam int unsigned T2_SW = 5;

    // Key roles within the selected target group
    localparam int unsigned INC_A = 0;
    localparam int unsigned DEC_A = 1;
    localparam int unsigned INC_B = 2;
    localparam int unsigned DEC_B = 3;

    // Slot order of the packed lvl output, LSB slot first
    localparam int unsigned SLOT_BRI     = 0;
    localparam int unsigned SLOT_CON     = 1;
    localparam int unsigned SLOT_GAUSS_A = 2;
    localparam int unsigned SLOT_GAUSS_B = 3;
    localparam int unsigned SLOT_CLR_A   = 4;
    localparam int unsigned SLOT_CLR_B   = 5;
    localparam int unsigned NUM_SLOTS    = 6;

    typedef enum logic [1:0] {
        TGT_BC    = 2'd0,
        TGT_GAUSS = 2'd1,
        TGT_CLR   = 2'd2
    } target_e;

    function automatic int unsigned lvl_default(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Per-key 2-flop synchroniser, debounce and press-edge pulse.
//                FILTER_CTRL_AUTOREPEAT_EN adds periodic repeat pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce #(
    parameter int unsigned DEB_CYC    = 50000
`ifdef FILTER_CTRL_AUTOREPEAT_EN
    , parameter int unsigned REPEAT_CYC = 12500000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_pulse
);

    localparam int unsigned    c_DEB_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYC - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_ONE  = c_DEB_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic [1:0]         r_vld;
    logic               r_armed;
    logic               r_stable;
    logic [c_DEB_W-1:0] r_cnt;
    logic               r_pulse;
    logic               w_take;
    logic               w_press;

    assign w_take  = (r_sync2 != r_stable) && (r_cnt == c_DEB_LAST);
    // A key held through reset is only armed once a real released sample arrives
    assign w_press = w_take && r_stable && r_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_vld    <= 2'b00;
            r_armed  <= 1'b0;
            r_stable <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            if (r_vld[1] && r_sync2) begin
                r_armed <= 1'b1;
            end
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_take) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_DEB_ONE;
            end
        end
    end

`ifdef FILTER_CTRL_AUTOREPEAT_EN
    localparam int unsigned        c_RPT_W    = $clog2(REPEAT_CYC);
    localparam logic [c_RPT_W-1:0] c_RPT_LAST = c_RPT_W'(REPEAT_CYC - 1);
    localparam logic [c_RPT_W-1:0] c_RPT_ONE  = c_RPT_W'(1);

    logic               r_rep_act;
    logic [c_RPT_W-1:0] r_rcnt;
    logic               w_repeat;

    assign w_repeat = r_rep_act && !r_stable && (r_rcnt == c_RPT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_act <= 1'b0;
            r_rcnt    <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_pulse <= w_press | w_repeat;
            if (w_press) begin
                r_rep_act <= 1'b1;
                r_rcnt    <= '0;
            end else if (r_stable) begin
                r_rep_act <= 1'b0;
                r_rcnt    <= '0;
            end else if (r_rep_act) begin
                r_rcnt <= w_repeat ? '0 : r_rcnt + c_RPT_ONE;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_press;
        end
    end
`endif

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/filter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : filter_ctrl
//  Description : KEY/SW user control for the filter pipeline; saturating level
//                registers with frame-synchronous shadow outputs.
//                Optional autorepeat: FILTER_CTRL_AUTOREPEAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module filter_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SW     = 10,
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned LVL_W      = 4,
    parameter int unsigned DEB_CYC    = 50000,
    parameter int unsigned REPEAT_CYC = 12500000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SW-1:0]          SW,
    input  logic [NUM_KEYS-1:0]        KEY,
    input  logic                       frame_start,
    output logic [NUM_SW-1:0]          en,
    output logic [NUM_KEYS-1:0]        key_pulse,
    output logic [NUM_SLOTS*LVL_W-1:0] lvl
);

    localparam logic [LVL_W-1:0] c_LVL_DEF = LVL_W'(lvl_default(LVL_W));
    localparam logic [LVL_W-1:0] c_LVL_MAX = {LVL_W{1'b1}};
    localparam logic [LVL_W-1:0] c_LVL_ONE = LVL_W'(1);

    if (NUM_KEYS != 4 || NUM_SW <= T2_SW || LVL_W < 2 || DEB_CYC < 1 || REPEAT_CYC < 2) begin : g_param_check
        $error("filter_ctrl: unsupported parameter set");
    end

    logic [NUM_SW-1:0]   r_sw_s1;
    logic [NUM_SW-1:0]   r_sw_s2;
    logic [NUM_SW-1:0]   r_en;
    logic [NUM_KEYS-1:0] w_key_pulse;
    target_e             w_tgt;
    logic                w_tgt_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
            r_en    <= '0;
        end else begin
            r_sw_s1 <= SW;
            r_sw_s2 <= r_sw_s1;
            if (frame_start) begin
                r_en <= r_sw_s2;
            end
        end
    end

    assign en = r_en;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
`ifdef FILTER_CTRL_AUTOREPEAT_EN
        key_debounce #(
            .DEB_CYC    (DEB_CYC),
            .REPEAT_CYC (REPEAT_CYC)
        ) u_key_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_key_n (KEY[k]),
            .o_pulse (w_key_pulse[k])
        );
`else
        key_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_key_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_key_n (KEY[k]),
            .o_pulse (w_key_pulse[k])
        );
`endif
    end

    assign key_pulse = w_key_pulse;

    // Lowest-index asserted target switch wins
    always_comb begin
        w_tgt     = TGT_BC;
        w_tgt_vld = 1'b0;
        if (r_sw_s2[T0_SW]) begin
            w_tgt     = TGT_BC;
            w_tgt_vld = 1'b1;
        end else if (r_sw_s2[T1_SW]) begin
            w_tgt     = TGT_GAUSS;
            w_tgt_vld = 1'b1;
        end else if (r_sw_s2[T2_SW]) begin
            w_tgt     = TGT_CLR;
            w_tgt_vld = 1'b1;
        end
    end

    // Even slots are driven by the A key pair, odd slots by the B pair
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        localparam int unsigned c_TGT   = s / 2;
        localparam int unsigned c_INC_K = (s % 2 == 0) ? INC_A : INC_B;
        localparam int unsigned c_DEC_K = (s % 2 == 0) ? DEC_A : DEC_B;

        logic             w_sel;
        logic             w_inc;
        logic             w_dec;
        logic [LVL_W-1:0] w_next;
        logic [LVL_W-1:0] r_work;
        logic [LVL_W-1:0] r_shadow;

        assign w_sel = w_tgt_vld && (w_tgt == target_e'(c_TGT));
        assign w_inc = w_sel && w_key_pulse[c_INC_K];
        assign w_dec = w_sel && w_key_pulse[c_DEC_K];

        always_comb begin
            w_next = r_work;
            if (w_inc && !w_dec && (r_work != c_LVL_MAX)) begin
                w_next = r_work + c_LVL_ONE;
            end else if (w_dec && !w_inc && (r_work != '0)) begin
                w_next = r_work - c_LVL_ONE;
            end
        end

        // Shadow samples r_work before this cycle's update lands
        always_ff @(posedge clk) begin
            if (rst) begin
                r_work   <= c_LVL_DEF;
                r_shadow <= c_LVL_DEF;
            end else begin
                r_work <= w_next;
                if (frame_start) begin
                    r_shadow <= r_work;
                end
            end
        end

        assign lvl[s*LVL_W +: LVL_W] = r_shadow;
    end

endmodule
`default_nettype wire

// File: tb/tb_filter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_ctrl
//  Description : Self-checking bench for filter_ctrl with a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_filter_ctrl;

    localparam int NUM_SW     = 10;
    localparam int NUM_KEYS   = 4;
    localparam int LVL_W      = 4;
    localparam int DEB_CYC    = 4;
    localparam int REPEAT_CYC = 8;
    localparam int LMAX       = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [9:0]  SW;
    logic [3:0]  KEY;
    logic [9:0]  en;
    logic [3:0]  key_pulse;
    logic [23:0] lvl;

    always #5 clk = ~clk;

    filter_ctrl #(
        .NUM_SW     (NUM_SW),
        .NUM_KEYS   (NUM_KEYS),
        .LVL_W      (LVL_W),
        .DEB_CYC    (DEB_CYC),
        .REPEAT_CYC (REPEAT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .SW          (SW),
        .KEY         (KEY),
        .frame_start (frame_start),
        .en          (en),
        .key_pulse   (key_pulse),
        .lvl         (lvl)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]  kh[$];
    logic [9:0]  swh[$];
    int          n;
    logic [3:0]  m_stable, m_armed, m_rep, m_pulse;
    int          m_last[4];
    int          m_w[6];
    logic [23:0] m_sh;
    logic [9:0]  m_en;

    // Raw key as seen by the debouncer at edge m (three cycles of pipeline)
    function automatic logic key_sample(input int m, input int k);
        if (m < 3) return 1'b1;
        return kh[m-3][k];
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] np;
        logic [9:0] ss;
        logic       flip;
        int         t, d, v;
        if (rst) begin
            n = 0;
            kh.delete();
            swh.delete();
            m_stable = 4'hF;
            m_armed  = 4'h0;
            m_rep    = 4'h0;
            m_pulse  = 4'h0;
            m_en     = '0;
            m_sh     = {6{4'd8}};
            for (int s = 0; s < 6; s++) m_w[s] = 8;
        end else begin
            n++;
            kh.push_back(KEY);
            swh.push_back(SW);
            ss = (n >= 3) ? swh[n-3] : 10'd0;
            if (frame_start) begin
                m_en = ss;
                for (int s = 0; s < 6; s++) m_sh[s*4 +: 4] = 4'(m_w[s]);
            end
            t = ss[1] ? 0 : ss[2] ? 1 : ss[5] ? 2 : -1;
            if (t >= 0) begin
                for (int h = 0; h < 2; h++) begin
                    d = int'(m_pulse[2*h]) - int'(m_pulse[2*h+1]);
                    v = m_w[2*t+h] + d;
                    m_w[2*t+h] = (v < 0) ? 0 : (v > LMAX) ? LMAX : v;
                end
            end
            np = 4'h0;
            for (int k = 0; k < 4; k++) begin
                flip = 1'b1;
                for (int j = 0; j < DEB_CYC; j++) begin
                    if ((n - j) < 1 || key_sample(n - j, k) == m_stable[k]) flip = 1'b0;
                end
                if (flip && m_stable[k] && m_armed[k]) begin
                    np[k] = 1'b1;
                    m_rep[k] = 1'b1;
                    m_last[k] = n;
                end else if (m_stable[k]) begin
                    m_rep[k] = 1'b0;
                end
`ifdef FILTER_CTRL_AUTOREPEAT_EN
                else if (m_rep[k] && (n - m_last[k]) == REPEAT_CYC) begin
                    np[k] = 1'b1;
                    m_last[k] = n;
                end
`endif
                if (n >= 3 && key_sample(n, k)) m_armed[k] = 1'b1;
                if (flip) m_stable[k] = ~m_stable[k];
            end
            m_pulse = np;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_key_pulse", 32'(key_pulse), 32'(m_pulse));
            check("model_en", 32'(en), 32'(m_en));
            check("model_lvl", 32'(lvl), 32'(m_sh));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    logic [63:0] mask;
    int          cnt;
    int          dur[4];

    initial begin
        rst = 1'b1;
        SW = '0;
        KEY = 4'hF;
        frame_start = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // reset state
        check("reset_en", 32'(en), 32'h0);
        check("reset_pulse", 32'(key_pulse), 32'h0);
        step();
        fs();
        check("reset_lvl", 32'(lvl), 32'h888888);

        // clean press on KEY0 with brightness/contrast target
        SW = 10'h002;
        repeat (4) step();
        KEY = 4'b1110;
        mask = '0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 7) KEY = 4'hF;
            if (key_pulse[0]) mask[i] = 1'b1;
        end
        check("press_latency", 32'(mask), 32'h40);
        fs();
        check("bri_inc", 32'(lvl[3:0]), 32'd9);
        check("con_hold", 32'(lvl[7:4]), 32'd8);

        // bounce shorter than the debounce window
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            KEY[0] = ((i / 2) % 2) != 0;
            step();
            if (key_pulse != 4'h0) cnt++;
        end
        KEY = 4'hF;
        repeat (10) begin
            step();
            if (key_pulse != 4'h0) cnt++;
        end
        check("bounce_pulses", 32'(cnt), 32'd0);
        fs();
        check("bounce_lvl", 32'(lvl), 32'h888889);

        // contrast decrement saturates at zero, gauss untouched
        SW = 10'h006;
        repeat (4) step();
        repeat (10) begin
            KEY = 4'b0111;
            repeat (6) step();
            KEY = 4'hF;
            repeat (8) step();
        end
        fs();
        check("con_sat", 32'(lvl[7:4]), 32'd0);
        check("gauss_b_hold", 32'(lvl[15:12]), 32'd8);
        check("bri_keep", 32'(lvl[3:0]), 32'd9);

        // enable changes only at frame start
        SW = 10'h020;
        repeat (6) step();
        check("en5_hold", 32'(en[5]), 32'd0);
        fs();
        check("en5_set", 32'(en), 32'h020);

        // reset in the middle of a press
        KEY = 4'b1110;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt = 0;
        repeat (15) begin
            step();
            if (key_pulse != 4'h0) cnt++;
        end
        check("rst_no_pulse", 32'(cnt), 32'd0);
        KEY = 4'hF;
        repeat (6) step();
        fs();
        check("rst_lvl", 32'(lvl), 32'h888888);
        KEY = 4'b1110;
        repeat (7) step();
        KEY = 4'hF;
        repeat (12) step();
        fs();
        check("clr_a_inc", 32'(lvl[19:16]), 32'd9);

        // held key: autorepeat train or single pulse
        SW = 10'h002;
        repeat (4) step();
        KEY = 4'b1110;
        mask = '0;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (i == 30) KEY = 4'hF;
            if (key_pulse[0]) mask[i] = 1'b1;
        end
`ifdef FILTER_CTRL_AUTOREPEAT_EN
        check("hold_pulses", 32'(mask), 32'h40404040);
`else
        check("hold_pulses", 32'(mask), 32'h40);
`endif

        // randomized traffic against the model
        for (int k = 0; k < 4; k++) dur[k] = 1;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) begin
                dur[k]--;
                if (dur[k] <= 0) begin
                    KEY[k] = ~KEY[k];
                    dur[k] = ($urandom_range(0, 9) < 4) ? $urandom_range(1, 3) : $urandom_range(6, 24);
                end
            end
            if ($urandom_range(0, 63) == 0) SW = 10'($urandom);
            frame_start = ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 799) == 0);
            step();
        end
        rst = 1'b0;
        frame_start = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
